beat_line_assembler: RTL
========================

# beat_line_assembler

Collects 64-bit data beats (id, offset, data) from the two-input beat arbiter's output and reassembles them into complete 512-bit lines, one assembly slot per id. Sits directly downstream of that arbiter. The arbiter's output has no ready, so this block accepts a beat every cycle unconditionally. Completed lines are presented on a valid/ready port to the line consumer (refill / writeback datapath). Protocol violations are flagged on sticky error outputs.

## Interface
- BEATS, 8, beats per line; power of two; offset width = log2(BEATS) = 3
- DATA_W, 64, beat width; line width = BEATS*DATA_W = 512
- IDS, 2, number of ids / assembly slots; id width = 1
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- io_in_valid  in  1  beat present this cycle; always accepted, no ready
- io_in_bits_id  in  1  slot select
- io_in_bits_offset  in  3  beat position within line
- io_in_bits_data  in  64  beat payload
- io_out_valid  out  1  completed line available
- io_out_ready  in  1  consumer accepts line
- io_out_bits_id  out  1  id of presented line
- io_out_bits_data  out  512  line; beat k at bits [64k+63:64k]
- io_busy  out  1  any slot not EMPTY
- io_err_overflow  out  1  sticky: beat dropped, slot FULL
- io_err_dup  out  1  sticky: beat dropped, offset already filled

## Operation
- Per slot: state EMPTY / FILLING / FULL, 8-bit beat mask, 8x64 data store.
- Accepted beat (io_in_valid, slot = id):
  - EMPTY: write data[offset], mask = 1<<offset, state -> FILLING (-> FULL if BEATS == 1).
  - FILLING, mask[offset] clear: write data, set mask bit; if mask becomes all ones -> FULL.
  - FILLING, mask[offset] set: beat dropped, data unchanged, io_err_dup set.
  - FULL and not drained this cycle: beat dropped, io_err_overflow set.
  - FULL and drained this cycle: slot treated as EMPTY for this beat (new line starts, mask = 1<<offset).
- Output selection: io_out_valid = any slot FULL. If both FULL, present the one that completed first (1-bit order register written on each FILLING->FULL transition). Since at most one beat arrives per cycle, two slots never complete in the same cycle.
- Drain: io_out_valid && io_out_ready -> presented slot -> EMPTY, mask cleared. Data store is not cleared.
- Stability: once io_out_valid is high, io_out_bits_id and io_out_bits_data hold until handshake; valid never retracts.
- Error flags: set on the cycle after the offending beat; cleared only by reset.
- io_busy = OR over slots of (state != EMPTY).

## Timing
- Reset (asynchronous assert, synchronous-clean release): all slots EMPTY, masks 0, order register 0.
- Reset values: io_out_valid 0, io_out_bits_id 0, io_out_bits_data 0, io_busy 0, io_err_overflow 0, io_err_dup 0.
- Latency: final beat sampled at edge N -> io_out_valid high after edge N (visible in cycle N+1). No combinational input->output path except io_out_ready -> none (outputs are registered state only).
- Throughput: one beat per cycle sustained. One line per cycle drain.
- Reset mid-line: partial masks discarded; no output for the interrupted line.
- Interleaved ids: beats for id 0 and id 1 may arrive in any order, in any offset order.

## Test plan
- In-order fill: id 0, offsets 0..7 with data 0x1000+k on consecutive cycles, ready=1 -> io_out_valid for one cycle after the 8th beat. io_out_bits_id=0, beat k = 0x1000+k. io_busy returns to 0.
- Interleaved out-of-order: id 1 offsets 7..0 interleaved with id 0 offsets 0..7, ready=0 until both are complete -> id 1 line presented first (completed first), then id 0. Data matches per offset. No error flags.
- Backpressure overflow: complete id 0, hold ready=0, send id 0 offset 3 -> beat dropped, io_err_overflow=1. Line data unchanged when finally drained.
- Drain-same-cycle refill: id 0 FULL, ready=1, and in the same cycle a beat arrives for id 0 offset 5 -> line drained, new line started with mask 0x20. No error.
- Duplicate offset: id 1 offset 2 data A, then offset 2 data B -> io_err_dup=1. After the remaining offsets, line beat 2 = A.
- Reset mid-operation: 4 beats into id 0, assert reset -> all outputs 0 immediately. After release, a full 8-beat line assembles correctly with no stale beats.

Source files
------------

// File: rtl/beat_line_assembler_if.sv
// beat_line_assembler_if
// Bundles the beat input, the completed-line output handshake and the status
// flags of beat_line_assembler.
//   master : beat producer / line consumer side (drives beats and out_ready)
//   slave  : the assembler (drives lines, busy and sticky error flags)
// Signal names follow the surrounding datapath's io_* naming.
interface beat_line_assembler_if #(
  parameter int unsigned BEATS  = 8,
  parameter int unsigned DATA_W = 64
) ();
  localparam int unsigned OffW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LineW = BEATS * DATA_W;

  logic              io_in_valid;
  logic              io_in_bits_id;
  logic [OffW-1:0]   io_in_bits_offset;
  logic [DATA_W-1:0] io_in_bits_data;
  logic              io_out_valid;
  logic              io_out_ready;
  logic              io_out_bits_id;
  logic [LineW-1:0]  io_out_bits_data;
  logic              io_busy;
  logic              io_err_overflow;
  logic              io_err_dup;

  modport master (
    output io_in_valid, io_in_bits_id, io_in_bits_offset, io_in_bits_data, io_out_ready,
    input  io_out_valid, io_out_bits_id, io_out_bits_data, io_busy, io_err_overflow,
           io_err_dup
  );

  modport slave (
    input  io_in_valid, io_in_bits_id, io_in_bits_offset, io_in_bits_data, io_out_ready,
    output io_out_valid, io_out_bits_id, io_out_bits_data, io_busy, io_err_overflow,
           io_err_dup
  );
endinterface

// File: rtl/beat_line_assembler.sv
// beat_line_assembler
// Reassembles DATA_W-bit beats (id, offset, data) into BEATS*DATA_W-bit lines,
// one assembly slot per id (two ids). Beats are accepted every cycle; there is
// no input ready. Completed lines are offered on a valid/ready port in
// completion order. Protocol violations set sticky error flags.
// Ports:
//   clock  : single rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : beat_line_assembler_if.slave
//            in  : io_in_valid, io_in_bits_id, io_in_bits_offset, io_in_bits_data,
//                  io_out_ready
//            out : io_out_valid, io_out_bits_id, io_out_bits_data (beat k at
//                  [k*DATA_W +: DATA_W]), io_busy, io_err_overflow, io_err_dup
// All outputs are functions of registered state only.
module beat_line_assembler #(
  parameter int unsigned BEATS  = 8,
  parameter int unsigned DATA_W = 64
) (
  input logic                  clock,
  input logic                  reset,
  beat_line_assembler_if.slave bus
);
  localparam int unsigned IDS = 2;

  localparam logic [1:0] StEmpty   = 2'd0;
  localparam logic [1:0] StFilling = 2'd1;
  localparam logic [1:0] StFull    = 2'd2;

  // Per-slot state
  logic [1:0]        r_state [IDS];
  logic [BEATS-1:0]  r_mask  [IDS];
  logic [DATA_W-1:0] r_data  [IDS][BEATS];
  // Id of the slot that most recently became FULL; when both slots are FULL
  // the other one completed first and is presented.
  logic              r_last;
  logic              r_err_overflow;
  logic              r_err_dup;

  logic [1:0]        w_state_d [IDS];
  logic [BEATS-1:0]  w_mask_d  [IDS];
  logic              w_last_d;
  logic              w_set_overflow;
  logic              w_set_dup;
  logic              w_wr;
  logic [IDS-1:0]    w_full;
  logic              w_out_valid;
  logic              w_sel;
  logic              w_drain;
  logic [BEATS-1:0]  w_bit;
  logic [1:0]        w_cur_state;
  logic [BEATS-1:0]  w_cur_mask;
  logic [BEATS-1:0]  w_new_mask;
  logic              w_busy;

  // Output selection
  always_comb begin
    for (int s = 0; s < IDS; s++) begin
      w_full[s] = (r_state[s] == StFull);
    end
  end

  assign w_out_valid = |w_full;
  assign w_sel       = (&w_full) ? ~r_last : w_full[1];
  assign w_drain     = w_out_valid & bus.io_out_ready;

  // Next-state: drain first, then apply the incoming beat to the post-drain
  // view so a slot drained this cycle accepts the beat as a fresh line.
  always_comb begin
    for (int s = 0; s < IDS; s++) begin
      w_state_d[s] = r_state[s];
      w_mask_d[s]  = r_mask[s];
    end
    w_last_d       = r_last;
    w_set_overflow = 1'b0;
    w_set_dup      = 1'b0;
    w_wr           = 1'b0;
    w_bit          = BEATS'(1) << bus.io_in_bits_offset;

    if (w_drain) begin
      w_state_d[w_sel] = StEmpty;
      w_mask_d[w_sel]  = '0;
    end

    w_cur_state = w_state_d[bus.io_in_bits_id];
    w_cur_mask  = w_mask_d[bus.io_in_bits_id];
    w_new_mask  = w_cur_mask | w_bit;

    if (bus.io_in_valid) begin
      case (w_cur_state)
        // An EMPTY slot always has a zero mask, so it shares the FILLING path.
        StEmpty, StFilling: begin
          if ((w_cur_mask & w_bit) != '0) begin
            w_set_dup = 1'b1;
          end else begin
            w_wr                        = 1'b1;
            w_mask_d[bus.io_in_bits_id] = w_new_mask;
            if (&w_new_mask) begin
              w_state_d[bus.io_in_bits_id] = StFull;
              w_last_d                     = bus.io_in_bits_id;
            end else begin
              w_state_d[bus.io_in_bits_id] = StFilling;
            end
          end
        end
        default: begin
          w_set_overflow = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < IDS; s++) begin
        r_state[s] <= StEmpty;
        r_mask[s]  <= '0;
      end
      r_last         <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_dup      <= 1'b0;
    end else begin
      for (int s = 0; s < IDS; s++) begin
        r_state[s] <= w_state_d[s];
        r_mask[s]  <= w_mask_d[s];
      end
      r_last <= w_last_d;
      if (w_set_overflow) r_err_overflow <= 1'b1;
      if (w_set_dup)      r_err_dup      <= 1'b1;
    end
  end

  // Data store is not reset; outputs are gated by valid so stale contents never
  // leak, and a FULL slot's contents are frozen until it drains.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_data[bus.io_in_bits_id][bus.io_in_bits_offset] <= bus.io_in_bits_data;
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int s = 0; s < IDS; s++) begin
      w_busy = w_busy | (r_state[s] != StEmpty);
    end
  end

  always_comb begin
    for (int k = 0; k < BEATS; k++) begin
      bus.io_out_bits_data[k*DATA_W +: DATA_W] = w_out_valid ? r_data[w_sel][k] : '0;
    end
  end

  assign bus.io_out_valid    = w_out_valid;
  assign bus.io_out_bits_id  = w_out_valid ? w_sel : 1'b0;
  assign bus.io_busy         = w_busy;
  assign bus.io_err_overflow = r_err_overflow;
  assign bus.io_err_dup      = r_err_dup;

endmodule
